// File: rtl/sram_controller.sv
// Bridges one 32-bit MEM-stage load/store onto a 16-bit asynchronous SRAM as two
// wait-stated half accesses (low half first). Holds 'ready' low while the access runs.
module sram_controller #(
  parameter int ADDR_BASE   = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [15:0]        SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N
);

  // state | meaning
  // IDLE  | waiting for rd_en/wr_en; latches op, address, data on request
  // LOW   | low half (SRAM word*2+0) driven for WAIT_CYCLES cycles
  // HIGH  | high half (SRAM word*2+1) driven for WAIT_CYCLES cycles
  // DONE  | one-cycle completion, ready=1, pipeline advances
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam int CW = $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic               op_wr;
  logic [SRAM_AW-2:0] word;
  logic [31:0]        wdata;
  logic [15:0]        lo_q;
  logic [31:0]        offset;
  logic               req, active, last;
  logic               offset_unused;

  assign req    = rd_en | wr_en;
  assign offset = address - 32'(ADDR_BASE);
  assign active = (state == LOW) || (state == HIGH);
  assign last   = (cnt == CNT_LAST);
  // byte-lane bits and the part above the SRAM window are discarded (wraps silently)
  assign offset_unused = ^{offset[31:SRAM_AW+1], offset[1:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req) state_nxt = LOW;
      LOW:  if (last) state_nxt = HIGH;
      HIGH: if (last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      word      <= '0;
      wdata     <= '0;
      lo_q      <= '0;
      read_data <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || !active) cnt <= '0;
      else                               cnt <= cnt + 1'b1;
      if (state == IDLE && req) begin
        op_wr <= wr_en;
        word  <= offset[SRAM_AW:2];
        wdata <= write_data;
      end
      if (state == LOW && last && !op_wr)  lo_q      <= SRAM_DQ;
      if (state == HIGH && last && !op_wr) read_data <= {SRAM_DQ, lo_q};
    end
  end

  assign ready     = (state == DONE) || (state == IDLE && !req);
  assign SRAM_ADDR = {word, state == HIGH};
  assign SRAM_WE_N = !(active && op_wr);
  assign SRAM_OE_N = !(active && !op_wr);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_DQ   = (active && op_wr) ? ((state == HIGH) ? wdata[31:16] : wdata[15:0]) : 16'hzzzz;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural async SRAM on the DQ bus.
module tb_sram_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  logic [15:0] mem [0:63];
  logic        probe;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  sram_controller dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_WE_N(sram_we_n),
    .SRAM_OE_N(sram_oe_n), .SRAM_CE_N(sram_ce_n), .SRAM_UB_N(sram_ub_n),
    .SRAM_LB_N(sram_lb_n)
  );

  // SRAM model drives on read; probe drives a marker when the bus should be released
  assign sram_dq = (sram_we_n && !sram_oe_n) ? mem[sram_addr[5:0]] :
                   (probe && sram_we_n && sram_oe_n) ? 16'h5A3C : 16'hzzzz;

  always @(posedge clk)
    if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Runs one access; returns in the first ready=1 cycle (DONE) with inputs still held
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output int lat, output int we_low,
                        output int oe_low, output logic [17:0] a_lo, output logic [17:0] a_hi);
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = addr; write_data = data;
    lat = 0; we_low = 0; oe_low = 0; a_lo = '1; a_hi = '1;
    forever begin
      #1;
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (lat == 1) a_lo = sram_addr;
      if (lat == 3) a_hi = sram_addr;
      if (ready) break;
      if (lat > 20) begin
        chk("timeout", 32'(lat), 32'd5);
        break;
      end
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    rd_en = 1'b0; wr_en = 1'b0;
    #1;
  endtask

  int          lat, we_low, oe_low, gap;
  logic [17:0] a_lo, a_hi;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    probe = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    probe = 1'b1;
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_rdata", read_data, 32'h0);
    chk("rst_strobes", {29'd0, sram_we_n, sram_oe_n, sram_ce_n}, 32'h6);
    chk("rst_addr", 32'(sram_addr), 32'h0);
    chk("rst_dq_z", 32'(sram_dq), 32'h5A3C);
    probe = 1'b0;
    @(negedge clk); rst = 1'b1;

    // store 0xDEADBEEF at word 0
    access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, lat, we_low, oe_low, a_lo, a_hi);
    chk("st_latency", 32'(lat), 32'd5);
    chk("st_we_cycles", 32'(we_low), 32'd4);
    chk("st_oe_cycles", 32'(oe_low), 32'd0);
    go_idle();
    chk("st_mem", {mem[1], mem[0]}, 32'hDEADBEEF);
    chk("idle_ready", 32'(ready), 32'd1);

    // load it back
    access(1'b1, 1'b0, 32'd1024, 32'h0, lat, we_low, oe_low, a_lo, a_hi);
    chk("ld_latency", 32'(lat), 32'd5);
    chk("ld_oe_cycles", 32'(oe_low), 32'd4);
    chk("ld_done_data", read_data, 32'hDEADBEEF);
    go_idle();
    repeat (3) @(negedge clk);
    chk("ld_hold", read_data, 32'hDEADBEEF);

    // back-to-back store/load at 1028
    access(1'b0, 1'b1, 32'd1028, 32'h12345678, lat, we_low, oe_low, a_lo, a_hi);
    chk("b2b_st_addr", {14'd0, a_hi, 14'd0, a_lo} >> 0, {14'd0, 18'd3, 14'd0, 18'd2} >> 0);
    chk("b2b_st_mem_pre", 32'(lat), 32'd5);
    access(1'b1, 1'b0, 32'd1028, 32'h0, lat, we_low, oe_low, a_lo, a_hi);
    chk("b2b_mem", {mem[3], mem[2]}, 32'h12345678);
    chk("b2b_ld_addr", {14'd0, a_hi[1:0], a_lo}, {14'd0, 2'd3, 18'd2});
    chk("b2b_ld_latency", 32'(lat), 32'd5);
    chk("b2b_ld_data", read_data, 32'h12345678);

    // both enables: write wins, read_data untouched
    access(1'b1, 1'b1, 32'd1032, 32'hA5A55A5A, lat, we_low, oe_low, a_lo, a_hi);
    chk("both_we_cycles", 32'(we_low), 32'd4);
    chk("both_rdata", read_data, 32'h12345678);
    go_idle();
    chk("both_mem", {mem[5], mem[4]}, 32'hA5A55A5A);

    // reset in the middle of the HIGH half of a store at 1036
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1036; write_data = 32'hCAFEF00D;
    gap = 0;
    repeat (3) begin
      @(negedge clk);
      gap++;
    end
    #1;
    chk("mid_in_high", 32'(sram_addr), 32'd7);
    rst = 1'b0; wr_en = 1'b0; probe = 1'b1;
    #1;
    chk("mid_rst_we", 32'(sram_we_n), 32'd1);
    chk("mid_rst_ready", 32'(ready), 32'd1);
    chk("mid_rst_dq_z", 32'(sram_dq), 32'h5A3C);
    chk("mid_rst_rdata", read_data, 32'h0);
    probe = 1'b0;
    @(negedge clk); rst = 1'b1;
    chk("mid_partial", {mem[7], mem[6]}, 32'h0000F00D);

    access(1'b1, 1'b0, 32'd1024, 32'h0, lat, we_low, oe_low, a_lo, a_hi);
    chk("post_rst_latency", 32'(lat), 32'd5);
    chk("post_rst_data", read_data, 32'hDEADBEEF);
    go_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
